// File: rtl/player_action_fsm.sv
// player_action_fsm: per-player fighter controller. Turns debounced controller
// levels plus opponent hit pulses into fighter state, screen position and shield
// energy. All game-state changes happen on the single clk where the game-tick
// divider wraps, and become visible on the same clk as the tick strobe.
module player_action_fsm #(
    parameter int unsigned TICK_DIV       = 833333,
    parameter int unsigned X_MIN          = 0,
    parameter int unsigned X_MAX          = 560,
    parameter int unsigned X_INIT         = 100,
    parameter int unsigned WALK_STEP      = 2,
    parameter int unsigned JUMP_V0        = 12,
    parameter int unsigned GRAVITY        = 1,
    parameter int unsigned ATTACK_TICKS   = 12,
    parameter int unsigned COOLDOWN_TICKS = 20,
    parameter int unsigned STUN_TICKS     = 30,
    parameter int unsigned SHIELD_MAX     = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       attack,
    input  logic       shield,
    input  logic       hit_in,
    output logic       tick,
    output logic [2:0] state,
    output logic [9:0] pos_x,
    output logic [7:0] pos_y,
    output logic       attack_active,
    output logic       shield_active,
    output logic       blocked,
    output logic [6:0] shield_energy
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 8;
    localparam int unsigned TMR_W = 8;
    localparam int unsigned EN_W  = 7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WALK     = 3'd1,
        ST_CROUCH   = 3'd2,
        ST_JUMP     = 3'd3,
        ST_ATTACK   = 3'd4,
        ST_COOLDOWN = 3'd5,
        ST_SHIELD   = 3'd6,
        ST_STUN     = 3'd7
    } state_t;

    // Registers
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_attack_q;
    logic                    r_atk_req;
    logic                    r_hit_req;
    state_t                  r_state;
    logic [X_W-1:0]          r_x;
    logic [Y_W-1:0]          r_y;
    logic signed [Y_W-1:0]   r_vel;
    logic [TMR_W-1:0]        r_timer;
    logic [EN_W-1:0]         r_energy;
    logic                    r_tick;
    logic                    r_attack_active;
    logic                    r_shield_active;
    logic                    r_blocked;

    // Combinational helpers and next-state values
    logic                    w_tick;
    logic                    w_atk_rise;
    logic [X_W-1:0]          w_x_inc;
    logic [X_W-1:0]          w_x_dec;
    logic [X_W-1:0]          w_x_steer;
    logic signed [Y_W+1:0]   w_y_sum;
    logic signed [Y_W-1:0]   w_vel_dec;
    logic [EN_W-1:0]         w_energy_up;
    logic [EN_W-1:0]         w_energy_dn;
    logic [TMR_W-1:0]        w_timer_dec;

    state_t                  w_state_n;
    logic [X_W-1:0]          w_x_n;
    logic [Y_W-1:0]          w_y_n;
    logic signed [Y_W-1:0]   w_vel_n;
    logic [TMR_W-1:0]        w_timer_n;
    logic [EN_W-1:0]         w_energy_n;
    logic                    w_blocked_n;

    // Game-tick strobe: the last count of each divider period
    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_atk_rise = attack & ~r_attack_q;

    // Saturating horizontal steps; left and right together cancel out
    assign w_x_inc   = ((11'(r_x) + 11'(WALK_STEP)) > 11'(X_MAX)) ? X_W'(X_MAX)
                                                                   : r_x + X_W'(WALK_STEP);
    assign w_x_dec   = (11'(r_x) < (11'(X_MIN) + 11'(WALK_STEP))) ? X_W'(X_MIN)
                                                                   : r_x - X_W'(WALK_STEP);
    assign w_x_steer = (left ^ right) ? (right ? w_x_inc : w_x_dec) : r_x;

    // Jump arithmetic in a widened signed domain so landing is detected cleanly
    assign w_y_sum   = $signed({2'b00, r_y}) + $signed({{2{r_vel[Y_W-1]}}, r_vel});
    assign w_vel_dec = r_vel - Y_W'(GRAVITY);

    // Shield energy drains inside SHIELD and recharges elsewhere, both saturating
    assign w_energy_up = (r_energy >= EN_W'(SHIELD_MAX)) ? EN_W'(SHIELD_MAX)
                                                         : r_energy + EN_W'(1);
    assign w_energy_dn = (r_energy == '0) ? '0 : r_energy - EN_W'(1);
    assign w_timer_dec = (r_timer == '0) ? '0 : r_timer - TMR_W'(1);

    // Tick divider and input request latches; requests seen on a tick clk carry over
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_attack_q <= 1'b0;
            r_atk_req  <= 1'b0;
            r_hit_req  <= 1'b0;
        end else begin
            r_cnt      <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_attack_q <= attack;
            r_atk_req  <= w_tick ? w_atk_rise : (r_atk_req | w_atk_rise);
            r_hit_req  <= w_tick ? hit_in : (r_hit_req | hit_in);
        end
    end

    // Next-state, position, timer and energy decisions; only a tick clk changes anything
    always_comb begin
        w_state_n   = r_state;
        w_x_n       = r_x;
        w_y_n       = r_y;
        w_vel_n     = r_vel;
        w_timer_n   = r_timer;
        w_energy_n  = r_energy;
        w_blocked_n = 1'b0;

        if (w_tick) begin
            w_energy_n = (r_state == ST_SHIELD) ? w_energy_dn : w_energy_up;

            if (r_hit_req && (r_state != ST_STUN)) begin
                if (r_state == ST_SHIELD) begin
                    w_blocked_n = 1'b1;
                end else begin
                    w_state_n = ST_STUN;
                    w_timer_n = TMR_W'(STUN_TICKS);
                    w_y_n     = '0;
                    w_vel_n   = '0;
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_WALK, ST_CROUCH: begin
                        if (r_atk_req) begin
                            w_state_n = ST_ATTACK;
                            w_timer_n = TMR_W'(ATTACK_TICKS);
                        end else if (shield && (r_energy != '0)) begin
                            w_state_n = ST_SHIELD;
                        end else if (up) begin
                            w_state_n = ST_JUMP;
                            w_vel_n   = Y_W'(JUMP_V0);
                        end else if (down) begin
                            w_state_n = ST_CROUCH;
                        end else if (left ^ right) begin
                            w_state_n = ST_WALK;
                            w_x_n     = w_x_steer;
                        end else begin
                            w_state_n = ST_IDLE;
                        end
                    end
                    ST_JUMP: begin
                        w_x_n = w_x_steer;
                        if (w_y_sum <= 10'sd0) begin
                            w_state_n = ST_IDLE;
                            w_y_n     = '0;
                            w_vel_n   = '0;
                        end else begin
                            w_y_n   = w_y_sum[Y_W-1:0];
                            w_vel_n = w_vel_dec;
                        end
                    end
                    ST_ATTACK: begin
                        if (w_timer_dec == '0) begin
                            w_state_n = ST_COOLDOWN;
                            w_timer_n = TMR_W'(COOLDOWN_TICKS);
                        end else begin
                            w_timer_n = w_timer_dec;
                        end
                    end
                    ST_COOLDOWN, ST_STUN: begin
                        w_timer_n = w_timer_dec;
                        if (w_timer_dec == '0) begin
                            w_state_n = ST_IDLE;
                        end
                    end
                    ST_SHIELD: begin
                        if (!shield || (w_energy_dn == '0)) begin
                            w_state_n = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State, position and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_x             <= X_W'(X_INIT);
            r_y             <= '0;
            r_vel           <= '0;
            r_timer         <= '0;
            r_energy        <= EN_W'(SHIELD_MAX);
            r_tick          <= 1'b0;
            r_attack_active <= 1'b0;
            r_shield_active <= 1'b0;
            r_blocked       <= 1'b0;
        end else begin
            r_state         <= w_state_n;
            r_x             <= w_x_n;
            r_y             <= w_y_n;
            r_vel           <= w_vel_n;
            r_timer         <= w_timer_n;
            r_energy        <= w_energy_n;
            r_tick          <= w_tick;
            r_attack_active <= (w_state_n == ST_ATTACK);
            r_shield_active <= (w_state_n == ST_SHIELD);
            r_blocked       <= w_blocked_n;
        end
    end

    assign tick          = r_tick;
    assign state         = r_state;
    assign pos_x         = r_x;
    assign pos_y         = r_y;
    assign attack_active = r_attack_active;
    assign shield_active = r_shield_active;
    assign blocked       = r_blocked;
    assign shield_energy = r_energy;

endmodule

// File: tb/tb_player_action_fsm.sv
// Testbench for player_action_fsm: a per-clk reference model pushes the expected
// fighter snapshot for every game tick; a monitor pops it when the DUT strobes tick.
module tb_player_action_fsm;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic       attack = 1'b0, shield = 1'b0, hit_in = 1'b0;
    logic       tick;
    logic [2:0] state;
    logic [9:0] pos_x;
    logic [7:0] pos_y;
    logic       attack_active, shield_active, blocked;
    logic [6:0] shield_energy;

    player_action_fsm #(.TICK_DIV(TD)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .left(left), .right(right), .up(up), .down(down),
        .attack(attack), .shield(shield), .hit_in(hit_in),
        .tick(tick), .state(state), .pos_x(pos_x), .pos_y(pos_y),
        .attack_active(attack_active), .shield_active(shield_active),
        .blocked(blocked), .shield_energy(shield_energy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int x; int y; int en;
        bit atk; bit shl; bit blk;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state (plain integers; state codes as in the port table)
    int m_cnt = 0, m_st = 0, m_x = 100, m_y = 0, m_vel = 0, m_tmr = 0, m_en = 120;
    bit m_atk_req = 0, m_hit_req = 0, m_attack_q = 0, m_rise = 0, exp_tick = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},  int'(state), 0);
        check({tag, "_pos_x"},  int'(pos_x), 100);
        check({tag, "_pos_y"},  int'(pos_y), 0);
        check({tag, "_tick"},   int'(tick), 0);
        check({tag, "_atk"},    int'(attack_active), 0);
        check({tag, "_shl"},    int'(shield_active), 0);
        check({tag, "_blk"},    int'(blocked), 0);
        check({tag, "_energy"}, int'(shield_energy), 120);
    endtask

    function automatic int clampx(input int v);
        return (v < 0) ? 0 : ((v > 560) ? 560 : v);
    endfunction

    // One game tick of the fighter rules, using the levels present this clk
    task automatic model_tick();
        int en_new;
        bit blk;
        blk    = 0;
        en_new = (m_st == 6) ? ((m_en > 0) ? m_en - 1 : 0) : ((m_en < 120) ? m_en + 1 : 120);
        if (m_hit_req && m_st != 7) begin
            if (m_st == 6) blk = 1;
            else begin m_st = 7; m_tmr = 30; m_y = 0; m_vel = 0; end
        end else begin
            case (m_st)
                0, 1, 2: begin
                    if (m_atk_req) begin m_st = 4; m_tmr = 12; end
                    else if (shield && m_en > 0) m_st = 6;
                    else if (up) begin m_st = 3; m_vel = 12; end
                    else if (down) m_st = 2;
                    else if (left != right) begin
                        m_st = 1;
                        m_x  = clampx(m_x + (right ? 2 : -2));
                    end else m_st = 0;
                end
                3: begin
                    if (left != right) m_x = clampx(m_x + (right ? 2 : -2));
                    if (m_y + m_vel <= 0) begin m_y = 0; m_vel = 0; m_st = 0; end
                    else begin m_y = m_y + m_vel; m_vel = m_vel - 1; end
                end
                4: begin
                    m_tmr = m_tmr - 1;
                    if (m_tmr == 0) begin m_st = 5; m_tmr = 20; end
                end
                5, 7: begin
                    m_tmr = m_tmr - 1;
                    if (m_tmr == 0) m_st = 0;
                end
                6: if (!shield || en_new == 0) m_st = 0;
                default: m_st = 0;
            endcase
        end
        m_en = en_new;
        e.st = m_st; e.x = m_x; e.y = m_y; e.en = m_en;
        e.atk = (m_st == 4); e.shl = (m_st == 6); e.blk = blk;
        exp_q.push_back(e);
    endtask

    // Reference model clocking: tick divider and request latches
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_st = 0; m_x = 100; m_y = 0; m_vel = 0; m_tmr = 0; m_en = 120;
            m_atk_req = 0; m_hit_req = 0; m_attack_q = 0; exp_tick = 0;
            exp_q.delete();
        end else begin
            m_rise     = attack && !m_attack_q;
            m_attack_q = attack;
            if (m_cnt == TD - 1) begin
                m_cnt    = 0;
                exp_tick = 1;
                model_tick();
                m_atk_req = m_rise;
                m_hit_req = hit_in;
            end else begin
                m_cnt     = m_cnt + 1;
                exp_tick  = 0;
                m_atk_req = m_atk_req | m_rise;
                m_hit_req = m_hit_req | hit_in;
            end
        end
    end

    // Monitor: tick timing every clk, full snapshot compare on each DUT tick
    always @(negedge clk) begin
        if (rst_n) begin
            check("tick_timing", int'(tick), int'(exp_tick));
            if (tick) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL scoreboard: DUT tick with no expected entry at %0t", $time);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("state",  int'(state), x.st);
                    check("pos_x",  int'(pos_x), x.x);
                    check("pos_y",  int'(pos_y), x.y);
                    check("energy", int'(shield_energy), x.en);
                    check("attack_active", int'(attack_active), int'(x.atk));
                    check("shield_active", int'(shield_active), int'(x.shl));
                    check("blocked", int'(blocked), int'(x.blk));
                end
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n * TD) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        ticks(5);
        // Walk right into X_MAX, then left into X_MIN
        right = 1'b1; ticks(235); right = 1'b0;
        left  = 1'b1; ticks(285); left  = 1'b0;
        // Jump from a single up pulse spanning one tick
        up = 1'b1; repeat (TD) @(negedge clk); up = 1'b0;
        ticks(30);
        // Attack pulse mid-period, second pulse lands in cooldown
        repeat (2) @(negedge clk);
        attack = 1'b1; @(negedge clk); attack = 1'b0;
        ticks(15);
        attack = 1'b1; @(negedge clk); attack = 1'b0;
        ticks(25);
        // Shield with a blocked hit, then drain to empty and recharge
        shield = 1'b1; ticks(3);
        hit_in = 1'b1; @(negedge clk); hit_in = 1'b0;
        ticks(125);
        shield = 1'b0; ticks(10);
        // Hit in mid-air, then asynchronous reset during stun
        up = 1'b1; repeat (TD) @(negedge clk); up = 1'b0;
        ticks(5);
        hit_in = 1'b1; @(negedge clk); hit_in = 1'b0;
        ticks(5);
        #2 rst_n = 1'b0;
        #1 check_reset("async");
        @(negedge clk); rst_n = 1'b1;

        // Randomized input levels and hit pulses
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) left   = ~left;
            if ($urandom_range(15) == 0) right  = ~right;
            if ($urandom_range(23) == 0) up     = ~up;
            if ($urandom_range(23) == 0) down   = ~down;
            if ($urandom_range(31) == 0) shield = ~shield;
            if ($urandom_range(5)  == 0) attack = ~attack;
            hit_in = ($urandom_range(39) == 0);
        end
        left = 0; right = 0; up = 0; down = 0; shield = 0; attack = 0; hit_in = 0;
        ticks(2);
        @(negedge clk);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
